// File: rtl/xadc_drp_arbiter.sv
// Sole owner of the XADC DRP port: arbitrates sequencer readout against a software DRP master,
// streams conversion results and counts lost EOCs and DRDY timeouts.
module xadc_drp_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eoc_i,
    input  logic [4:0]  channel_i,
    input  logic        sw_req_i,
    input  logic        sw_we_i,
    input  logic [6:0]  sw_addr_i,
    input  logic [15:0] sw_wdata_i,
    output logic        sw_ack_o,
    output logic        sw_err_o,
    output logic [15:0] sw_rdata_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        res_valid_o,
    output logic [6:0]  res_addr_o,
    output logic [15:0] res_data_o,
    output logic [15:0] drop_cnt_o,
    output logic [7:0]  to_cnt_o
);
    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [4:0]  pch_q, pch_d;
    logic        prio_sw_q, prio_sw_d;
    logic        own_sw_q, own_sw_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        dwe_q, dwe_d;
    logic [15:0] di_q, di_d;
    logic [15:0] sw_rdata_q, sw_rdata_d;
    logic [6:0]  res_addr_q, res_addr_d;
    logic [15:0] res_data_q, res_data_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;

    logic        seq_req;
    logic [4:0]  seq_ch;
    logic        grant;
    logic        grant_sw;
    logic [1:0]  drop_inc;
    logic        to_inc;

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        seq_req  = pend_q | eoc_i;
        seq_ch   = eoc_i ? channel_i : pch_q;
        grant    = (state_q == StIdle) && (seq_req || sw_req_i);
        // On a tie the owner not granted last wins; prio_sw_q remembers who that is.
        grant_sw = (seq_req && sw_req_i) ? prio_sw_q : sw_req_i;
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pch_d      = pch_q;
        prio_sw_d  = prio_sw_q;
        own_sw_d   = own_sw_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        daddr_d    = daddr_q;
        dwe_d      = dwe_q;
        di_d       = di_q;
        sw_rdata_d = sw_rdata_q;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        drop_inc   = 2'd0;
        to_inc     = 1'b0;

        if (eoc_i) begin
            pend_d = 1'b1;
            pch_d  = channel_i;
        end
        // A newer EOC always supersedes an unread one, granted this cycle or not.
        if (eoc_i && pend_q) begin
            drop_inc = 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d   = StIssue;
                    own_sw_d  = grant_sw;
                    tmo_d     = 1'b0;
                    prio_sw_d = ~grant_sw;
                    if (grant_sw) begin
                        daddr_d = sw_addr_i;
                        dwe_d   = sw_we_i;
                        di_d    = sw_wdata_i;
                    end else begin
                        daddr_d = {2'b00, seq_ch};
                        dwe_d   = 1'b0;
                        di_d    = 16'h0000;
                        pend_d  = 1'b0;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = 8'd1;
            end
            StWait: begin
                if (drp_drdy_i) begin
                    state_d = StDone;
                    if (own_sw_q) begin
                        sw_rdata_d = drp_do_i;
                    end else begin
                        res_data_d = drp_do_i;
                        res_addr_d = daddr_q;
                    end
                end else if (cnt_q >= TimeoutVal) begin
                    state_d = StDone;
                    tmo_d   = 1'b1;
                    to_inc  = 1'b1;
                    if (own_sw_q) begin
                        sw_rdata_d = 16'h0000;
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
        to_cnt_d   = (to_inc && (to_cnt_q != 8'hFF)) ? to_cnt_q + 8'd1 : to_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pch_q      <= 5'd0;
            prio_sw_q  <= 1'b0;
            own_sw_q   <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= 8'd0;
            daddr_q    <= 7'd0;
            dwe_q      <= 1'b0;
            di_q       <= 16'h0000;
            sw_rdata_q <= 16'h0000;
            res_addr_q <= 7'd0;
            res_data_q <= 16'h0000;
            drop_cnt_q <= 16'h0000;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pch_q      <= pch_d;
            prio_sw_q  <= prio_sw_d;
            own_sw_q   <= own_sw_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            daddr_q    <= daddr_d;
            dwe_q      <= dwe_d;
            di_q       <= di_d;
            sw_rdata_q <= sw_rdata_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
            drop_cnt_q <= drop_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign drp_den_o   = (state_q == StIssue);
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;
    assign sw_ack_o    = (state_q == StDone) && own_sw_q;
    assign sw_err_o    = (state_q == StDone) && own_sw_q && tmo_q;
    assign sw_rdata_o  = sw_rdata_q;
    assign res_valid_o = (state_q == StDone) && !own_sw_q && !tmo_q;
    assign res_addr_o  = res_addr_q;
    assign res_data_o  = res_data_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign to_cnt_o    = to_cnt_q;

endmodule
